ustc_sched: RTL
===============

// Module: ustc_sched
// PURPOSE
//   Sequencer for the unstructured sparse tensor-core array. Takes compressed A beats and
//   dense B vectors from valid/ready feeders and issues them to the array in tile order:
//   B latched once per tile, then cfg_n_step A beats streamed against it. Drives the array's
//   a/b/col/row/ctrl inputs, tracks pipeline latency to flag results, pulses done at job end.
// PARAMETERS
//   N_UNIT     32  multiplier lanes per A beat
//   N_XBAR_IN  8   B vector elements per tile
//   DW_DATA    8   element width
//   DW_ROW     4   per-lane output-row tag width
//   DW_CTRL    4   per-lane ctrl width
//   DW_IDX     4   per-lane column index width (selects B element)
//   DW_CNT     8   step/tile counter width
//   PIPE_LAT   4   cycles from issue to array output valid (>=1)
// PORTS
//   clk        in   1                  clock
//   reset      in   1                  async active-high reset
//   cfg_start  in   1                  job start pulse, sampled in IDLE only
//   cfg_n_step in   DW_CNT             A beats per tile
//   cfg_n_tile in   DW_CNT             tiles per job
//   a_valid    in   1                  A beat available
//   a_ready    out  1                  A beat accepted when a_valid&a_ready
//   a_data     in   N_UNIT*DW_DATA     A nonzero values
//   a_col      in   N_UNIT*DW_IDX      A column indices
//   a_row      in   N_UNIT*DW_ROW      A row tags
//   b_valid    in   1                  B vector available
//   b_ready    out  1                  B accepted when b_valid&b_ready
//   b_data     in   N_XBAR_IN*DW_DATA  B vector
//   arr_in_a   out  N_UNIT*DW_DATA     to array in_a      (registered)
//   arr_in_b   out  N_XBAR_IN*DW_DATA  to array in_b      (registered, held per tile)
//   arr_a_col  out  N_UNIT*DW_IDX      to array in_a_col  (registered)
//   arr_a_row  out  N_UNIT*DW_ROW      to array in_a_row  (registered)
//   arr_a_ctrl out  N_UNIT*DW_CTRL     to array in_a_ctrl (registered)
//   res_valid  out  1                  array output valid this cycle
//   res_last   out  1                  res_valid beat is last of its tile
//   busy       out  1                  high in any state except IDLE
//   done       out  1                  one-cycle pulse at job end
// BEHAVIOUR
//   Reset: state IDLE, counters 0, all outputs 0 (arr_* 0, ready 0, res_valid/res_last 0,
//   busy 0, done 0), latency shift register cleared. Reset mid-job aborts with no done.
//   FSM: IDLE -cfg_start-> LOAD_B; if cfg_n_step==0 or cfg_n_tile==0 -> DONE instead.
//     LOAD_B: b_ready=1, a_ready=0; on b handshake latch arr_in_b, step_cnt=0 -> STREAM.
//     STREAM: a_ready=1, b_ready=0; each a handshake is an issue: next cycle arr_in_a/col/row
//       take the beat, every lane's ctrl = {1'b0, valid=1, last, first}; first when
//       step_cnt==0, last when step_cnt==cfg_n_step-1. No handshake -> next cycle arr_in_a,
//       col, row, ctrl all 0 (bubble). On last issue: tile_cnt==cfg_n_tile-1 -> DRAIN, else
//       tile_cnt++ -> LOAD_B.
//     DRAIN: no issue; wait until latency shift register is empty -> DONE.
//     DONE: done=1 for one cycle -> IDLE. busy=0 only in IDLE.
//   cfg_n_step/cfg_n_tile captured at cfg_start; later changes ignored. cfg_start outside IDLE
//   ignored. arr_in_b stable throughout STREAM; only changes on LOAD_B handshake.
//   Latency: PIPE_LAT-deep shift of {issue,last}; res_valid/res_last = tap PIPE_LAT cycles
//   after the handshake cycle. Counters compare with ==, no wrap; max 2^DW_CNT-1 steps/tiles.
//   Throughput: one A beat per cycle in STREAM; one bubble cycle per tile for LOAD_B min.
// TESTING
//   n_step=3,n_tile=1, a/b always valid -> 3 issues on consecutive cycles, ctrl lanes 0x5,0x4,
//     0x6; res_valid high 3 cycles starting PIPE_LAT after first handshake; done after drain.
//   n_step=2,n_tile=2, b_data=0x01..08 then 0x11..18 -> arr_in_b changes only after tile0 last
//     issue + LOAD_B handshake; res_last asserted on 2nd and 4th result.
//   a_valid toggled 1,0,1 in STREAM -> arr_* all zero on bubble cycle, step_cnt not advanced.
//   cfg_n_step=0 -> busy 1 cycle, done pulse, a_ready/b_ready never high, res_valid never high.
//   reset asserted mid-STREAM -> all outputs 0 immediately, no done, res_valid stays 0 after.
//   cfg_start pulsed while busy -> ignored; job completes with original counts.

Source files
------------

// File: rtl/ustc_sched.sv
// ustc_sched: tile sequencer for the sparse tensor-core array.
// Ports: cfg_* job setup, a_*/b_* valid/ready feeders, arr_* registered
// array drive, res_valid/res_last latency-tracked result flags,
// busy/done job status. Async active-high reset.
module ustc_sched #(
  parameter int N_UNIT    = 32,
  parameter int N_XBAR_IN = 8,
  parameter int DW_DATA   = 8,
  parameter int DW_ROW    = 4,
  parameter int DW_CTRL   = 4,
  parameter int DW_IDX    = 4,
  parameter int DW_CNT    = 8,
  parameter int PIPE_LAT  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_start,
  input  logic [DW_CNT-1:0]              cfg_n_step,
  input  logic [DW_CNT-1:0]              cfg_n_tile,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [N_UNIT*DW_DATA-1:0]      a_data,
  input  logic [N_UNIT*DW_IDX-1:0]       a_col,
  input  logic [N_UNIT*DW_ROW-1:0]       a_row,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [N_XBAR_IN*DW_DATA-1:0]   b_data,
  output logic [N_UNIT*DW_DATA-1:0]      arr_in_a,
  output logic [N_XBAR_IN*DW_DATA-1:0]   arr_in_b,
  output logic [N_UNIT*DW_IDX-1:0]       arr_a_col,
  output logic [N_UNIT*DW_ROW-1:0]       arr_a_row,
  output logic [N_UNIT*DW_CTRL-1:0]      arr_a_ctrl,
  output logic                           res_valid,
  output logic                           res_last,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DW_CNT-1:0]   n_step, n_tile;
  logic [DW_CNT-1:0]   step_cnt, tile_cnt;
  logic [PIPE_LAT-1:0] v_sr, l_sr;
  logic                a_fire, b_fire;
  logic                step_last, tile_last;
  logic [DW_CTRL-1:0]  lane_ctrl;

  assign a_ready   = (state == S_STREAM);
  assign b_ready   = (state == S_LOAD_B);
  assign a_fire    = a_valid & a_ready;
  assign b_fire    = b_valid & b_ready;
  assign step_last = (step_cnt == n_step - DW_CNT'(1));
  assign tile_last = (tile_cnt == n_tile - DW_CNT'(1));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign res_valid = v_sr[PIPE_LAT-1];
  assign res_last  = l_sr[PIPE_LAT-1];

  // lane ctrl = {0, valid, last, first}
  always_comb begin
    lane_ctrl      = '0;
    lane_ctrl[2:0] = {1'b1, step_last, step_cnt == '0};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (cfg_start)
          state_nx = (cfg_n_step == '0 || cfg_n_tile == '0)
                     ? S_DONE : S_LOAD_B;
      S_LOAD_B:
        if (b_fire) state_nx = S_STREAM;
      S_STREAM:
        if (a_fire && step_last)
          state_nx = tile_last ? S_DRAIN : S_LOAD_B;
      S_DRAIN:
        if (v_sr == '0) state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      n_step     <= '0;
      n_tile     <= '0;
      step_cnt   <= '0;
      tile_cnt   <= '0;
      v_sr       <= '0;
      l_sr       <= '0;
      arr_in_a   <= '0;
      arr_in_b   <= '0;
      arr_a_col  <= '0;
      arr_a_row  <= '0;
      arr_a_ctrl <= '0;
    end else begin
      state <= state_nx;
      // shift form works for PIPE_LAT == 1 as well
      v_sr  <= (v_sr << 1) | PIPE_LAT'(a_fire);
      l_sr  <= (l_sr << 1) | PIPE_LAT'(a_fire & step_last);
      if (state == S_IDLE && cfg_start) begin
        n_step   <= cfg_n_step;
        n_tile   <= cfg_n_tile;
        tile_cnt <= '0;
      end
      if (b_fire) begin
        arr_in_b <= b_data;
        step_cnt <= '0;
      end
      if (a_fire) begin
        arr_in_a   <= a_data;
        arr_a_col  <= a_col;
        arr_a_row  <= a_row;
        arr_a_ctrl <= {N_UNIT{lane_ctrl}};
        step_cnt   <= step_cnt + DW_CNT'(1);
        if (step_last) tile_cnt <= tile_cnt + DW_CNT'(1);
      end else begin
        arr_in_a   <= '0;
        arr_a_col  <= '0;
        arr_a_row  <= '0;
        arr_a_ctrl <= '0;
      end
    end
  end

endmodule
